ram_fifo_ctrl: RTL

RAM_FIFO_CTRL -- requirements
Module: ram_fifo_ctrl

---
 rtl/ram_fifo_pkg.sv | 7 +
 rtl/ram_fifo_ctrl_ptr_cnt.sv | 17 +
 rtl/ram_fifo_ctrl.sv | 69 ++++++
 3 files changed

// File: rtl/ram_fifo_pkg.sv
// ram_fifo_pkg: shared sizes and FSM state type for the RAM-backed FIFO controller.
package ram_fifo_pkg;
    localparam int DATA_W = 8;
    localparam int ADDR_W = 4;
    localparam int DEPTH  = 2 ** ADDR_W;
    typedef enum logic {S_IDLE, S_RD} state_t;
endpackage

// File: rtl/ram_fifo_ctrl_ptr_cnt.sv
// ptr_cnt: mod-DEPTH counter with enable and synchronous active-low reset.
module ptr_cnt #(
    parameter int W     = 4,
    parameter int DEPTH = 2 ** W
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         en,
    output logic [W-1:0] q
);
    always_ff @(posedge clk) begin
        if (!rst_n)
            q <= '0;
        else if (en)
            q <= (q == W'(DEPTH - 1)) ? '0 : q + W'(1);
    end
endmodule

// File: rtl/ram_fifo_ctrl.sv
// ram_fifo_ctrl: 16-deep FIFO on an external single-port RAM with registered read data;
// reads take priority over writes, and out_data is a one-word output register.
module ram_fifo_ctrl #(
    parameter int DATA_W = ram_fifo_pkg::DATA_W,
    parameter int ADDR_W = ram_fifo_pkg::ADDR_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [ADDR_W:0]   level,
    output logic              ram_wr,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_din,
    input  logic [DATA_W-1:0] ram_dout
);
    import ram_fifo_pkg::*;

    state_t            state, state_nx;
    logic              rd_issue, wr;
    logic [ADDR_W-1:0] wr_ptr, rd_ptr;

    ptr_cnt #(.W(ADDR_W), .DEPTH(2 ** ADDR_W)) u_wr_ptr (.clk(clk), .rst_n(rst_n), .en(wr), .q(wr_ptr));
    ptr_cnt #(.W(ADDR_W), .DEPTH(2 ** ADDR_W)) u_rd_ptr (.clk(clk), .rst_n(rst_n), .en(rd_issue), .q(rd_ptr));

    // level tops out at exactly 2**ADDR_W, so its MSB alone marks full
    always_comb begin
        rd_issue = state == S_IDLE && level != '0 && (!out_valid || out_ready);
        in_ready = rst_n && !level[ADDR_W] && !rd_issue;
        wr       = in_valid && in_ready;
        ram_wr   = wr;
        ram_addr = wr ? wr_ptr : rd_ptr;
        ram_din  = wr ? in_data : '0;
        state_nx = rd_issue ? S_RD : S_IDLE;
    end

    always_ff @(posedge clk) begin
        if (!rst_n)
            state <= S_IDLE;
        else
            state <= state_nx;
    end

    always_ff @(posedge clk) begin
        if (!rst_n)
            level <= '0;
        else if (rd_issue)
            level <= level - (ADDR_W + 1)'(1);
        else if (wr)
            level <= level + (ADDR_W + 1)'(1);
    end

    // a capture in S_RD overrides a simultaneous pop of the previous word
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_data  <= '0;
        end else if (state == S_RD) begin
            out_valid <= 1'b1;
            out_data  <= ram_dout;
        end else if (out_valid && out_ready) begin
            out_valid <= 1'b0;
        end
    end
endmodule
